// File: rtl/fp_norm_pipe73_pkg.sv
// Shared types for the post-addition normaliser pipeline.
// Direction encoding, status flag bundle and shift-count width helper.
package fp73_pkg;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
        logic inexact;
    } flags_t;

    function automatic int shift_w(input int mw);
        return $clog2(mw);
    endfunction

endpackage

// File: rtl/fp_norm_pipe73_if.sv
// Valid/ready bundle between mantissa adder, normaliser and packer.
// slave is the normaliser's view, master the surrounding datapath's.
interface fp_norm_pipe73_if #(
    parameter int MW = 12,
    parameter int EW = 5
);
    logic          in_valid73;
    logic          in_ready73;
    logic [MW-1:0] m_sum73;
    logic [EW-1:0] exp_in73;
    logic          sign_in73;
    logic          out_valid73;
    logic          out_ready73;
    logic [MW-2:0] m_out73;
    logic [EW-1:0] exp_out73;
    logic          sign_out73;
    logic          ovf73;
    logic          unf73;
    logic          zero73;
    logic          inexact73;

    modport slave (
        input  in_valid73, m_sum73, exp_in73, sign_in73, out_ready73,
        output in_ready73, out_valid73, m_out73, exp_out73, sign_out73,
        output ovf73, unf73, zero73, inexact73
    );

    modport master (
        output in_valid73, m_sum73, exp_in73, sign_in73, out_ready73,
        input  in_ready73, out_valid73, m_out73, exp_out73, sign_out73,
        input  ovf73, unf73, zero73, inexact73
    );
endinterface

// File: rtl/fp_norm_pipe73_lod.sv
// Leading-one detector: shift direction and distance that bring the
// leading one of the mantissa sum to the hidden-bit position.
module lead_one_det73
    import fp73_pkg::*;
#(
    parameter int MW = 12,
    parameter int NW = 4
) (
    input  logic [MW-1:0] m_i,
    output dir_e          dir_o,
    output logic [NW-1:0] n_o,
    output logic          zero_o
);

    always_comb begin
        dir_o  = DIR_LEFT;
        n_o    = '0;
        zero_o = (m_i == '0);
        if (m_i[MW-1]) begin
            dir_o = DIR_RIGHT;
            n_o   = NW'(1);
        end else begin
            // Ascending scan: the highest set bit wins.
            for (int k = 0; k < MW - 1; k++) begin
                if (m_i[k]) n_o = NW'(MW - 2 - k);
            end
        end
    end

endmodule

// File: rtl/fp_norm_pipe73.sv
// Two-stage post-addition normaliser: leading-one detect, then shift
// with exponent adjust and overflow/underflow/zero/inexact flagging.
module fp_norm_pipe73
    import fp73_pkg::*;
#(
    parameter int MW = 12,
    parameter int EW = 5
) (
    input  logic              clk73,
    input  logic              rst_n73,
    fp_norm_pipe73_if.slave   bus
);

    localparam int NW = shift_w(MW);
    localparam int XW = (EW + 1 > NW) ? EW + 1 : NW + 1;
    localparam logic [EW-1:0] EMAX = '1;

    dir_e          lod_dir;
    logic [NW-1:0] lod_n;
    logic          lod_zero;

    logic          s1_valid_q;
    dir_e          s1_dir_q;
    logic [NW-1:0] s1_n_q;
    logic          s1_zero_q;
    logic [MW-1:0] s1_m_q;
    logic [EW-1:0] s1_exp_q;
    logic          s1_sign_q;

    logic          s2_valid_q;
    logic [MW-2:0] m_out_q;
    logic [EW-1:0] exp_out_q;
    logic          sign_q;
    flags_t        flags_q;

    logic [MW-2:0] m_out_d;
    logic [EW-1:0] exp_out_d;
    flags_t        flags_d;

    logic          s1_adv;
    logic          s2_adv;
    logic          in_fire;

    logic [XW-1:0] exp_x;
    logic [XW-1:0] n_x;
    logic [XW-1:0] exp_inc;
    logic [XW-1:0] exp_dec;
    logic [MW-1:0] m_shl;

    lead_one_det73 #(
        .MW(MW),
        .NW(NW)
    ) u_lod (
        .m_i   (bus.m_sum73),
        .dir_o (lod_dir),
        .n_o   (lod_n),
        .zero_o(lod_zero)
    );

    assign s2_adv         = !s2_valid_q | bus.out_ready73;
    assign s1_adv         = !s1_valid_q | s2_adv;
    assign bus.in_ready73 = rst_n73 & s1_adv;
    assign in_fire        = bus.in_valid73 & bus.in_ready73;

    // Widened exponent math exposes wrap past all-ones and borrow below zero.
    assign exp_x   = XW'(s1_exp_q);
    assign n_x     = XW'(s1_n_q);
    assign exp_inc = exp_x + XW'(1);
    assign exp_dec = exp_x - n_x;
    assign m_shl   = s1_m_q << s1_n_q;

    always_comb begin
        m_out_d   = '0;
        exp_out_d = '0;
        flags_d   = '0;
        if (s1_zero_q) begin
            flags_d.zero = 1'b1;
        end else if (s1_dir_q == DIR_RIGHT) begin
            if (exp_inc >= XW'(EMAX)) begin
                flags_d.ovf     = 1'b1;
                flags_d.inexact = 1'b1;
                exp_out_d       = EMAX;
            end else begin
                m_out_d         = s1_m_q[MW-1:1];
                exp_out_d       = exp_inc[EW-1:0];
                flags_d.inexact = s1_m_q[0];
            end
        end else begin
            if (exp_x <= n_x) begin
                flags_d.unf     = 1'b1;
                flags_d.inexact = 1'b1;
            end else begin
                m_out_d   = m_shl[MW-2:0];
                exp_out_d = exp_dec[EW-1:0];
            end
        end
    end

    always_ff @(posedge clk73 or negedge rst_n73) begin
        if (!rst_n73) begin
            s1_valid_q <= 1'b0;
            s1_dir_q   <= DIR_LEFT;
            s1_n_q     <= '0;
            s1_zero_q  <= 1'b0;
            s1_m_q     <= '0;
            s1_exp_q   <= '0;
            s1_sign_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            m_out_q    <= '0;
            exp_out_q  <= '0;
            sign_q     <= 1'b0;
            flags_q    <= '0;
        end else begin
            if (s1_adv) s1_valid_q <= bus.in_valid73;
            if (in_fire) begin
                s1_dir_q  <= lod_dir;
                s1_n_q    <= lod_n;
                s1_zero_q <= lod_zero;
                s1_m_q    <= bus.m_sum73;
                s1_exp_q  <= bus.exp_in73;
                s1_sign_q <= bus.sign_in73;
            end
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s2_adv & s1_valid_q) begin
                m_out_q   <= m_out_d;
                exp_out_q <= exp_out_d;
                sign_q    <= s1_sign_q;
                flags_q   <= flags_d;
            end
        end
    end

    assign bus.out_valid73 = s2_valid_q;
    assign bus.m_out73     = m_out_q;
    assign bus.exp_out73   = exp_out_q;
    assign bus.sign_out73  = sign_q;
    assign bus.ovf73       = flags_q.ovf;
    assign bus.unf73       = flags_q.unf;
    assign bus.zero73      = flags_q.zero;
    assign bus.inexact73   = flags_q.inexact;

endmodule

// File: tb/tb_fp_norm_pipe73.sv
// Bench for fp_norm_pipe73 (MW=12, EW=5): directed cases, backpressure,
// mid-stall reset and random traffic against a behavioural scoreboard.
module tb_fp_norm_pipe73;

    typedef struct packed {
        logic [10:0] m;
        logic [4:0]  e;
        logic        s;
        logic        ovf;
        logic        unf;
        logic        zero;
        logic        inx;
    } res_t;

    logic clk73 = 1'b0;
    logic rst_n73 = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    res_t exp_q[$];

    always #5 clk73 = ~clk73;

    fp_norm_pipe73_if #(.MW(12), .EW(5)) bus();

    fp_norm_pipe73 #(.MW(12), .EW(5)) dut (
        .clk73  (clk73),
        .rst_n73(rst_n73),
        .bus    (bus)
    );

    // Reference: find the leading one, then apply the normalisation rules.
    function automatic res_t model(input logic [11:0] m, input logic [4:0] e,
                                   input logic s);
        res_t r;
        int   k;
        int   n;
        int   ne;
        logic [11:0] sh;
        r   = '0;
        r.s = s;
        k   = -1;
        for (int i = 0; i < 12; i++) if (m[i]) k = i;
        if (k < 0) begin
            r.zero = 1'b1;
        end else if (k == 11) begin
            ne = int'(e) + 1;
            if (ne >= 31) begin
                r.ovf = 1'b1;
                r.inx = 1'b1;
                r.e   = 5'd31;
            end else begin
                r.m   = m[11:1];
                r.e   = 5'(ne);
                r.inx = m[0];
            end
        end else begin
            n = 10 - k;
            if (int'(e) <= n) begin
                r.unf = 1'b1;
                r.inx = 1'b1;
            end else begin
                sh  = m << n;
                r.m = sh[10:0];
                r.e = 5'(int'(e) - n);
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask

    function automatic res_t dut_res();
        return {bus.m_out73, bus.exp_out73, bus.sign_out73,
                bus.ovf73, bus.unf73, bus.zero73, bus.inexact73};
    endfunction

    // Scoreboard: check every valid output cycle, push accepted inputs.
    always begin
        @(negedge clk73);
        #2;
        if (!rst_n73) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid73) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_out: got %0h, expected no beat",
                             dut_res());
                end else begin
                    chk("out_beat", 64'(dut_res()), 64'(exp_q[0]));
                    if (bus.out_ready73) void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid73 && bus.in_ready73)
                exp_q.push_back(model(bus.m_sum73, bus.exp_in73, bus.sign_in73));
        end
    end

    task automatic send(input logic [11:0] m, input logic [4:0] e,
                        input logic s);
        int t;
        t = 0;
        @(negedge clk73);
        bus.in_valid73 = 1'b1;
        bus.m_sum73    = m;
        bus.exp_in73   = e;
        bus.sign_in73  = s;
        #1;
        while (!bus.in_ready73 && t < 50) begin
            @(negedge clk73);
            #1;
            t++;
        end
        if (!bus.in_ready73) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk73);
    endtask

    task automatic idle();
        @(negedge clk73);
        bus.in_valid73 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle();
        bus.out_ready73 = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid73) && t < 30) begin
            @(negedge clk73);
            #3;
            t++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d beats left, expected 0",
                     exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        logic [11:0] rm;
        bus.in_valid73  = 1'b0;
        bus.m_sum73     = '0;
        bus.exp_in73    = '0;
        bus.sign_in73   = 1'b0;
        bus.out_ready73 = 1'b1;

        // Pin the reference model with hand-computed results.
        chk("pin_right", 64'(model(12'h800, 5'd10, 1'b0)),
            64'({11'h400, 5'd11, 1'b0, 4'b0000}));
        chk("pin_left10", 64'(model(12'h001, 5'd20, 1'b0)),
            64'({11'h400, 5'd10, 1'b0, 4'b0000}));
        chk("pin_right_inx", 64'(model(12'h801, 5'd7, 1'b0)),
            64'({11'h400, 5'd8, 1'b0, 4'b0001}));
        chk("pin_zero", 64'(model(12'h000, 5'd9, 1'b1)),
            64'({11'h000, 5'd0, 1'b1, 4'b0010}));
        chk("pin_ovf", 64'(model(12'h801, 5'd30, 1'b0)),
            64'({11'h000, 5'd31, 1'b0, 4'b1001}));
        chk("pin_unf", 64'(model(12'h040, 5'd4, 1'b0)),
            64'({11'h000, 5'd0, 1'b0, 4'b0101}));
        chk("pin_unf_edge", 64'(model(12'h040, 5'd5, 1'b0)),
            64'({11'h400, 5'd1, 1'b0, 4'b0000}));

        #1;
        chk("rst_out_valid", 64'(bus.out_valid73), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready73), 64'd0);
        chk("rst_outputs", 64'(dut_res()), 64'd0);
        @(negedge clk73);
        @(negedge clk73);
        rst_n73 = 1'b1;
        #1;
        chk("rel_in_ready", 64'(bus.in_ready73), 64'd1);

        // Latency: accepted at edge 1, visible after edge 2.
        send(12'h800, 5'd10, 1'b0);
        idle();
        #1;
        chk("lat_not_yet", 64'(bus.out_valid73), 64'd0);
        @(negedge clk73);
        #1;
        chk("lat_valid", 64'(bus.out_valid73), 64'd1);
        chk("lat_value", 64'(dut_res()), 64'({11'h400, 5'd11, 1'b0, 4'b0000}));

        send(12'h001, 5'd20, 1'b0);
        send(12'h801, 5'd7, 1'b0);
        send(12'h000, 5'd9, 1'b1);
        send(12'h801, 5'd30, 1'b0);
        send(12'h801, 5'd31, 1'b1);
        send(12'h040, 5'd4, 1'b0);
        send(12'h040, 5'd5, 1'b0);
        send(12'h400, 5'd0, 1'b1);
        drain();

        // Backpressure: two beats fill the pipe, then in_ready drops.
        bus.out_ready73 = 1'b0;
        send(12'h123, 5'd15, 1'b0);
        send(12'h9ab, 5'd3, 1'b1);
        @(negedge clk73);
        bus.in_valid73 = 1'b1;
        bus.m_sum73    = 12'h00f;
        bus.exp_in73   = 5'd12;
        #1;
        chk("bp_in_ready", 64'(bus.in_ready73), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid73), 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk73);
            #1;
            chk("bp_hold_ready", 64'(bus.in_ready73), 64'd0);
        end
        bus.out_ready73 = 1'b1;
        send(12'h00f, 5'd12, 1'b0);
        send(12'hfff, 5'd29, 1'b1);
        send(12'h002, 5'd9, 1'b0);
        drain();

        // Reset in the middle of a stall discards in-flight beats.
        bus.out_ready73 = 1'b0;
        send(12'h555, 5'd17, 1'b1);
        send(12'h777, 5'd18, 1'b0);
        @(negedge clk73);
        bus.in_valid73 = 1'b0;
        #3;
        rst_n73 = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid73), 64'd0);
        chk("mid_rst_ready", 64'(bus.in_ready73), 64'd0);
        chk("mid_rst_outputs", 64'(dut_res()), 64'd0);
        @(negedge clk73);
        @(negedge clk73);
        rst_n73 = 1'b1;
        bus.out_ready73 = 1'b1;
        #1;
        chk("post_rst_ready", 64'(bus.in_ready73), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk73);
            #1;
            chk("post_rst_empty", 64'(bus.out_valid73), 64'd0);
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk73);
            rm = 12'($urandom) >> $urandom_range(0, 12);
            bus.in_valid73  = ($urandom_range(0, 9) < 7);
            bus.m_sum73     = rm;
            bus.exp_in73    = 5'($urandom);
            bus.sign_in73   = 1'($urandom);
            bus.out_ready73 = ($urandom_range(0, 9) < 7);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
